bram_fill: RTL and testbench
============================

# bram_fill

Writer-side engine for the 32-bit block-RAM port used by the BRAM summing path. While `start` is held, the block writes a generated data pattern to addresses 0..MAX, one word per clock. It accumulates a running 32-bit checksum of every word written, so a later read-back sum can be compared against `sum`. It uses the same level-held `start`/`done` handshake and 12-bit address / 32-bit data port shape as the reader.

## Interface
- `MAX`, default 1023: last address written. Legal range 0..4095. A run writes MAX+1 words.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: synchronous, active-high. Dominates `start`.
- `start` input, 1 bit: level-held run request. Dropping it aborts or clears a run.
- `mode` input, 2 bits: pattern select. Latched on the run-start edge.
- `seed` input, 32 bits: pattern seed. Latched on the run-start edge.
- `done` output, 1 bit: run complete. Held until `start` drops.
- `addr` output, 12 bits: BRAM write address.
- `wdata` output, 32 bits: BRAM write data.
- `we` output, 1 bit: BRAM write enable. Data and address are valid when high.
- `sum` output, 32 bits: modulo-2^32 sum of all words written this run.

## Operation
- FSM states: IDLE, WRITE, DONE. All outputs are registered.
- Reset, or `start`=0 in any state:
  - next state is IDLE;
  - `we`=0, `addr`=0, `wdata`=0, `sum`=0, `done`=0.
- IDLE with `start`=1 (run-start edge):
  - latch `mode` and `seed`;
  - load `we`=1, `addr`=0, `wdata`=p(0);
  - go to WRITE.
- WRITE, on each edge where `we`=1:
  - `sum` <= `sum` + `wdata`, wrapping at 2^32.
  - If `addr` != MAX: `addr` <= `addr`+1, `wdata` <= p(`addr`+1), stay in WRITE.
  - If `addr` == MAX: `we` <= 0, `done` <= 1, `addr` holds MAX, go to DONE.
- DONE:
  - `we`=0; `done`=1; `sum` and `addr` frozen.
  - Remains here while `start`=1, so there is no auto-restart.
  - A new run requires `start` low for at least 1 cycle.
- Patterns, with k = word index, p() = 32 bits, arithmetic mod 2^32:
  - mode 0, increment: p(k) = seed + k.
  - mode 1, constant: p(k) = seed.
  - mode 2, LFSR:
    - p(0) = seed, or 1 if seed == 0;
    - p(k+1) = (p(k) >> 1) ^ (p(k)[0] ? 32'h80200003 : 0).
  - mode 3, inverted address: p(k) = ~{20'b0, k}. `seed` is ignored.
- Changes to `mode`/`seed` after the run-start edge have no effect on the current run.
- Abort: `start` dropping mid-WRITE:
  - clears everything on that edge, with no further write;
  - a partial BRAM image is acceptable;
  - the next run restarts at address 0.

## Timing
- Edge e0 is the run-start edge. Address k is presented (`we`=1) in the cycle after edge ek, for k = 0..MAX.
- Edge e(MAX+1): `we` falls and `done` rises. The final `sum` is valid in the same cycle `done` is first high.
- Start-to-done latency: MAX+1 edges after e0. Writes are back-to-back with no bubbles.
- MAX=0 boundary: exactly one write, at address 0, then `done`.
- `start` low on the same edge as the `addr`==MAX write: abort wins, and `done` stays 0.
- `reset` together with `start`: reset wins, and all outputs return to 0.

## Test plan
- MAX=1023, mode 0, seed 0:
  - 1024 writes, addr 0..1023 with wdata = addr;
  - `done` high exactly 1024 cycles after the first write;
  - `sum` = 0x0007FE00.
- mode 1, seed 5: every wdata = 5, `sum` = 5120.
- mode 0, seed 0xFFFFFFFF: wdata sequence FFFFFFFF, 0, 1, ...; wrap checked; `sum` = 522752 (0x0007FA00).
- mode 2, seed 0:
  - first words 0x00000001, 0x80200003;
  - `sum` compared against the bench's LFSR model.
- mode 3: wdata(0) = 0xFFFFFFFF, wdata(1023) = 0xFFFFFC00; `sum` = 0xFFF7FE00.
- Abort and restart:
  - drop `start` after 10 writes: `we`, `addr`, `sum`, `done` are all 0 on the next cycle;
  - reassert `start`: writes restart at addr 0;
  - holding `start` high in DONE gives no second run;
  - `reset` mid-run clears all outputs.

Source files
------------

// File: rtl/bram_fill.sv
// bram_fill: writer-side BRAM fill engine. While start is held it writes a
// generated pattern to addresses 0..MAX, one word per clock, and keeps a
// modulo-2^32 running sum of every word written.
module bram_fill #(
    parameter int unsigned MAX = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [31:0] seed,
    output logic        done,
    output logic [11:0] addr,
    output logic [31:0] wdata,
    output logic        we,
    output logic [31:0] sum
);

    localparam logic [11:0] LAST_ADDR = 12'(MAX);
    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  mode_q,  mode_d;
    logic        done_q,  done_d;
    logic [11:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q,    we_d;
    logic [31:0] sum_q,   sum_d;

    logic [31:0] first_word;
    logic [31:0] next_word;
    logic [11:0] addr_inc;

    assign addr_inc = addr_q + 12'd1;

    // First pattern word from the live mode/seed, taken on the run-start edge.
    always_comb begin
        first_word = seed;
        unique case (mode)
            2'd0:    first_word = seed;
            2'd1:    first_word = seed;
            2'd2:    first_word = (seed == '0) ? 32'd1 : seed;
            default: first_word = '1;
        endcase
    end

    // Next pattern word derived from the word currently on the bus, so the
    // seed itself never needs to be stored beyond the first word.
    always_comb begin
        next_word = wdata_q;
        unique case (mode_q)
            2'd0:    next_word = wdata_q + 32'd1;
            2'd1:    next_word = wdata_q;
            2'd2:    next_word = (wdata_q >> 1) ^ (wdata_q[0] ? LFSR_TAPS : '0);
            default: next_word = ~{20'b0, addr_inc};
        endcase
    end

    // FSM next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        done_d  = done_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        sum_d   = sum_q;

        if (!start) begin
            state_d = IDLE;
            mode_d  = '0;
            done_d  = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
            we_d    = 1'b0;
            sum_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = WRITE;
                    mode_d  = mode;
                    done_d  = 1'b0;
                    addr_d  = '0;
                    wdata_d = first_word;
                    we_d    = 1'b1;
                    sum_d   = '0;
                end
                WRITE: begin
                    sum_d = sum_q + wdata_q;
                    if (addr_q != LAST_ADDR) begin
                        addr_d  = addr_inc;
                        wdata_d = next_word;
                    end else begin
                        we_d    = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    we_d   = 1'b0;
                    done_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    we_d    = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset dominates start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= '0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            sum_q   <= sum_d;
        end
    end

    assign done  = done_q;
    assign addr  = addr_q;
    assign wdata = wdata_q;
    assign we    = we_q;
    assign sum   = sum_q;

endmodule

// File: tb/tb_bram_fill.sv
// tb_bram_fill: directed and randomized runs of bram_fill checked against a
// word-index pattern model and a running modulo-2^32 sum.
module tb_bram_fill;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] seed;
    logic        done;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] sum;

    logic        start0;
    logic        done0;
    logic [11:0] addr0;
    logic [31:0] wdata0;
    logic        we0;
    logic [31:0] sum0;

    int checks = 0;
    int errors = 0;

    bram_fill #(.MAX(1023)) u_dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .seed(seed),
        .done(done), .addr(addr), .wdata(wdata), .we(we), .sum(sum)
    );

    bram_fill #(.MAX(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .mode(mode), .seed(seed),
        .done(done0), .addr(addr0), .wdata(wdata0), .we(we0), .sum(sum0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_we"},    32'(we),    32'd0);
        chk({tag, "_addr"},  32'(addr),  32'd0);
        chk({tag, "_wdata"}, wdata,      32'd0);
        chk({tag, "_sum"},   sum,        32'd0);
        chk({tag, "_done"},  32'(done),  32'd0);
    endtask

    // Pattern word k computed straight from the pattern rules; the LFSR
    // case walks forward from the previous model word.
    function automatic logic [31:0] pat(input logic [1:0] m, input logic [31:0] s,
                                        input int unsigned k, input logic [31:0] prev);
        logic [31:0] kk;
        kk = 32'(k);
        case (m)
            2'd0: return s + kk;
            2'd1: return s;
            2'd2: begin
                if (k == 0) return (s == 0) ? 32'd1 : s;
                return (prev >> 1) ^ (prev[0] ? 32'h80200003 : 32'h0);
            end
            default: return ~kk;
        endcase
    endfunction

    // Full run on the MAX=1023 instance, including DONE hold and clear.
    task automatic run(input logic [1:0] m, input logic [31:0] s, input string tag,
                       input bit use_lit, input logic [31:0] lit);
        logic [31:0] p;
        logic [31:0] tot;
        p   = '0;
        tot = '0;
        @(negedge clk);
        mode  = m;
        seed  = s;
        start = 1'b1;
        for (int unsigned k = 0; k <= 1023; k++) begin
            p = pat(m, s, k, p);
            @(posedge clk);
            #1;
            chk({tag, "_we"},    32'(we),   32'd1);
            chk({tag, "_addr"},  32'(addr), k);
            chk({tag, "_wdata"}, wdata,     p);
            chk({tag, "_done"},  32'(done), 32'd0);
            tot  = tot + p;
            mode = 2'($urandom);
            seed = $urandom;
        end
        @(posedge clk);
        #1;
        chk({tag, "_done_rise"}, 32'(done), 32'd1);
        chk({tag, "_we_fall"},   32'(we),   32'd0);
        chk({tag, "_addr_last"}, 32'(addr), 32'd1023);
        chk({tag, "_sum"},       sum,       tot);
        if (use_lit) chk({tag, "_sum_const"}, sum, lit);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_hold_done"}, 32'(done), 32'd1);
        chk({tag, "_hold_we"},   32'(we),   32'd0);
        chk({tag, "_hold_addr"}, 32'(addr), 32'd1023);
        chk({tag, "_hold_sum"},  sum,       tot);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk_idle({tag, "_clear"});
    endtask

    initial begin
        logic [31:0] rs;
        reset  = 1'b1;
        start  = 1'b0;
        start0 = 1'b0;
        mode   = '0;
        seed   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        @(negedge clk);
        reset = 1'b0;

        run(2'd0, 32'h0,        "inc0",  1'b1, 32'h0007FE00);
        run(2'd1, 32'd5,        "const", 1'b1, 32'd5120);
        run(2'd0, 32'hFFFFFFFF, "wrap",  1'b1, 32'h0007FA00);
        run(2'd2, 32'h0,        "lfsr0", 1'b0, 32'h0);
        run(2'd3, $urandom,     "inv",   1'b1, 32'hFFF7FE00);
        for (int i = 0; i < 4; i++) begin
            run(2'($urandom), $urandom, "rand", 1'b0, 32'h0);
        end

        // Abort after 10 writes, then a full run must restart at address 0.
        @(negedge clk);
        mode  = 2'd0;
        seed  = $urandom;
        start = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_pre_addr", 32'(addr), 32'd9);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk_idle("abort");
        run(2'd1, $urandom, "restart", 1'b0, 32'h0);

        // Abort on the same edge as the final write: done must stay low.
        @(negedge clk);
        mode  = 2'd3;
        start = 1'b1;
        repeat (1024) @(posedge clk);
        #1;
        chk("lastabort_addr", 32'(addr), 32'd1023);
        chk("lastabort_we",   32'(we),   32'd1);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk_idle("lastabort");

        // Reset mid-run with start still high clears everything.
        @(negedge clk);
        mode  = 2'd0;
        seed  = 32'd100;
        start = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_pre_wdata", wdata, 32'd119);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_idle("midreset");
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);

        // MAX=0 instance: a single write at address 0, then done.
        rs = $urandom;
        @(negedge clk);
        mode   = 2'd1;
        seed   = rs;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        chk("max0_we",    32'(we0),   32'd1);
        chk("max0_addr",  32'(addr0), 32'd0);
        chk("max0_wdata", wdata0,     rs);
        chk("max0_done0", 32'(done0), 32'd0);
        @(posedge clk);
        #1;
        chk("max0_done",  32'(done0), 32'd1);
        chk("max0_we_lo", 32'(we0),   32'd0);
        chk("max0_sum",   sum0,       rs);
        repeat (2) @(posedge clk);
        #1;
        chk("max0_hold_we", 32'(we0), 32'd0);
        @(negedge clk);
        start0 = 1'b0;
        @(posedge clk);
        #1;
        chk("max0_clear_done", 32'(done0), 32'd0);
        chk("max0_clear_sum",  sum0,       32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
